demux1to2_buf: RTL and testbench
================================

// Module: demux1to2_buf
// PURPOSE
//  1-to-2 registered demultiplexer: the inverse of the 2:1 datapath mux. One
//  valid/ready input stream is steered by select S into one of two output
//  channels, each with a 1-entry output register. Used in the pipeline to
//  route a single result bus (e.g. ALU/load result) to one of two consumers
//  with back-pressure. Also keeps a per-channel delivered-word count.
// PARAMETERS
//  DSize    32  data width of I, Y0, Y1
//  CntSize  16  width of per-channel transfer counters cnt0/cnt1
// PORTS
//  clk         in   1        clock; all state updates on rising edge
//  rst_n       in   1        synchronous reset, active-low
//  in_valid    in   1        input word I valid
//  in_ready    out  1        block can accept I this cycle
//  S           in   1        destination select: 0 -> channel 0, 1 -> channel 1
//  I           in   DSize    input data
//  out0_valid  out  1        Y0 holds an undelivered word
//  out0_ready  in   1        channel-0 consumer accepts Y0
//  Y0          out  DSize    channel-0 data
//  out1_valid  out  1        Y1 holds an undelivered word
//  out1_ready  in   1        channel-1 consumer accepts Y1
//  Y1          out  DSize    channel-1 data
//  cnt0        out  CntSize  channel-0 words delivered (mod 2^CntSize)
//  cnt1        out  CntSize  channel-1 words delivered (mod 2^CntSize)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out0_valid=out1_valid=0, Y0=Y1=0,
//    cnt0=cnt1=0. Any held word is discarded; no handshake completes that cycle.
//  - Per channel k, state EMPTY (outk_valid=0) / FULL (outk_valid=1).
//  - in_ready is combinational: S=0 -> (!out0_valid | out0_ready);
//    S=1 -> (!out1_valid | out1_ready). in_ready = 0 while rst_n=0.
//  - Accept = in_valid & in_ready. The accepted word goes to channel S:
//    Y_S <= I and outS_valid <= 1 at the next edge. Latency is 1 cycle.
//  - Pop_k = outk_valid & outk_ready. When pop without accept on k:
//    outk_valid <= 0, and Yk holds its last value.
//  - Pop and accept on the same channel in one cycle: outk_valid stays 1 and
//    Yk <= I. This gives full throughput of 1 word/cycle per channel.
//  - The non-selected channel is never written by an accept. It pops
//    independently, so both channels may pop in the same cycle.
//  - cntk increments by 1 on each Pop_k and wraps 2^CntSize-1 -> 0.
//  - Yk and outk_valid never change while outk_valid=1 & outk_ready=0,
//    unless rst_n=0.
//  - in_valid=0: no state change except pops. S and I are don't-care.
//  - No combinational path from I to Y0/Y1. The only comb paths are
//    S/out*_ready -> in_ready.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles with in_valid=1 -> in_ready=0,
//    outs valid=0, Y=0, cnt=0.
//  2 Steer: S=0,I=32'hA5A5_0001 then S=1,I=32'h0000_BEEF, ready=1
//    -> Y0=A5A50001 at +1, Y1=0000BEEF at +2, each valid for 1 cycle.
//  3 Stall: out0_ready=0, send S=0 I=1 then S=0 I=2 -> second held
//    (in_ready=0), Y0=1 stable. Then S=1 I=3 -> accepted, Y1=3 while Y0 stalls.
//  4 Throughput: out0_ready=1, 8 back-to-back S=0 words 1..8 -> in_ready=1
//    every cycle, Y0 sequence 1..8, cnt0=8.
//  5 Wrap: CntSize=4, deliver 17 words to ch1 -> cnt1=1, cnt0=0.
//  6 Mid-op reset: both channels FULL and stalled, rst_n=0 1 cycle
//    -> both valid=0, counters 0, old data never delivered.

Source files
------------

// File: rtl/demux1to2_buf_if.sv
// Purpose: bundles the input stream, both output channels and counters of demux1to2_buf.
// Latency: n/a (wiring only).
// Backpressure: valid/ready per stream; master is the environment, slave is the demux.
interface demux1to2_buf_if #(
  parameter int DSize   = 32,
  parameter int CntSize = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               S;
  logic [DSize-1:0]   I;
  logic               out0_valid;
  logic               out0_ready;
  logic [DSize-1:0]   Y0;
  logic               out1_valid;
  logic               out1_ready;
  logic [DSize-1:0]   Y1;
  logic [CntSize-1:0] cnt0;
  logic [CntSize-1:0] cnt1;

  modport master (
    output in_valid, S, I, out0_ready, out1_ready,
    input  in_ready, out0_valid, Y0, out1_valid, Y1, cnt0, cnt1
  );

  modport slave (
    input  in_valid, S, I, out0_ready, out1_ready,
    output in_ready, out0_valid, Y0, out1_valid, Y1, cnt0, cnt1
  );
endinterface

// File: rtl/demux1to2_buf.sv
// Purpose: steers one valid/ready stream into one of two registered output channels, counting deliveries.
// Latency: 1 cycle from accept to the word appearing on the selected channel.
// Backpressure: in_ready follows the selected channel only; a full channel is refilled in the cycle it pops.
module demux1to2_buf #(
  parameter int DSize   = 32,
  parameter int CntSize = 16
) (
  input logic             clk,
  input logic             rst_n,
  demux1to2_buf_if.slave  bus
);

  logic               v0_q;
  logic               v1_q;
  logic [DSize-1:0]   y0_q;
  logic [DSize-1:0]   y1_q;
  logic [CntSize-1:0] cnt0_q;
  logic [CntSize-1:0] cnt1_q;

  logic in_ready;
  logic accept;
  logic acc0;
  logic acc1;
  logic pop0;
  logic pop1;

  // Ready depends only on the selected channel having room (empty or draining now).
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = bus.S ? (!v1_q || bus.out1_ready) : (!v0_q || bus.out0_ready);
    end
  end

  assign accept = bus.in_valid & in_ready;
  assign acc0   = accept & !bus.S;
  assign acc1   = accept &  bus.S;
  assign pop0   = v0_q & bus.out0_ready;
  assign pop1   = v1_q & bus.out1_ready;

  // Channel registers and delivery counters; data only moves on accept, so a stalled word is frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      y0_q   <= '0;
      y1_q   <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      v0_q <= acc0 | (v0_q & !pop0);
      v1_q <= acc1 | (v1_q & !pop1);
      if (acc0) y0_q <= bus.I;
      if (acc1) y1_q <= bus.I;
      if (pop0) cnt0_q <= cnt0_q + CntSize'(1);
      if (pop1) cnt1_q <= cnt1_q + CntSize'(1);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = v0_q;
  assign bus.out1_valid = v1_q;
  assign bus.Y0         = y0_q;
  assign bus.Y1         = y1_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux1to2_buf.sv
// Purpose: scoreboard bench for demux1to2_buf plus a narrow-counter instance for wrap-around.
// Latency: expects words one cycle after accept on the selected channel.
// Backpressure: drives per-channel ready patterns, including long stalls and mid-stall reset.
module tb_demux1to2_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux1to2_buf_if #(.DSize(32), .CntSize(16)) bus ();
  demux1to2_buf_if #(.DSize(32), .CntSize(4))  wbus ();

  demux1to2_buf #(.DSize(32), .CntSize(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  demux1to2_buf #(.DSize(32), .CntSize(4)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivery seen on a channel must match the oldest expected word for it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.out0_valid && bus.out0_ready) begin
          if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL ch0_unexpected: got %h expected none", bus.Y0);
          end else chk("ch0_data", bus.Y0, q0.pop_front());
        end
        if (bus.out1_valid && bus.out1_ready) begin
          if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL ch1_unexpected: got %h expected none", bus.Y1);
          end else chk("ch1_data", bus.Y1, q1.pop_front());
        end
      end
    end
  end

  // Present one word; first_try demands acceptance in the first cycle.
  task automatic send(input logic s, input logic [31:0] d, input bit first_try);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.S        = s;
    bus.I        = d;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1;
        if (s) q1.push_back(d); else q0.push_back(d);
      end else if (first_try) begin
        checks++; failures++;
        $display("FAIL in_ready_first: got 0 expected 1 (data %h)", d);
        first_try = 0;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no accept expected accept (data %h)", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [15:0] c0_start;
    int w_acc;

    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.S = 1'b0; bus.I = 32'hDEAD_BEEF;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    wbus.in_valid = 1'b0; wbus.S = 1'b1; wbus.I = '0;
    wbus.out0_ready = 1'b1; wbus.out1_ready = 1'b1;

    // 1: reset held two cycles with a word offered
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_v0", {31'b0, bus.out0_valid}, 32'd0);
    chk("rst_v1", {31'b0, bus.out1_valid}, 32'd0);
    chk("rst_y0", bus.Y0, 32'd0);
    chk("rst_y1", bus.Y1, 32'd0);
    chk("rst_cnt0", {16'b0, bus.cnt0}, 32'd0);
    chk("rst_cnt1", {16'b0, bus.cnt1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    idle(1);

    // 2: steer one word to each channel
    send(1'b0, 32'hA5A5_0001, 1);
    send(1'b1, 32'h0000_BEEF, 1);
    idle(3);
    chk("steer_cnt0", {16'b0, bus.cnt0}, 32'd1);
    chk("steer_cnt1", {16'b0, bus.cnt1}, 32'd1);
    chk("steer_v0_cleared", {31'b0, bus.out0_valid}, 32'd0);
    chk("steer_v1_cleared", {31'b0, bus.out1_valid}, 32'd0);

    // 3: channel 0 stalled; second ch0 word held, ch1 word passes
    bus.out0_ready = 1'b0;
    send(1'b0, 32'd1, 1);
    bus.in_valid = 1'b1; bus.S = 1'b0; bus.I = 32'd2;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_y0", bus.Y0, 32'd1);
      chk("stall_v0", {31'b0, bus.out0_valid}, 32'd1);
      @(posedge clk); #1;
    end
    send(1'b1, 32'd3, 1);
    idle(2);
    chk("stall_y0_after_ch1", bus.Y0, 32'd1);
    chk("stall_cnt1", {16'b0, bus.cnt1}, 32'd2);
    bus.out0_ready = 1'b1;
    idle(2);
    chk("stall_cnt0", {16'b0, bus.cnt0}, 32'd2);

    // 4: back-to-back throughput on channel 0
    c0_start = bus.cnt0;
    for (int k = 1; k <= 8; k++) send(1'b0, k, 1);
    idle(3);
    chk("thru_cnt0_delta", {16'b0, bus.cnt0 - c0_start}, 32'd8);

    // 6: both channels full and stalled, then reset discards them
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    send(1'b0, 32'h0000_0111, 1);
    send(1'b1, 32'h0000_0222, 1);
    idle(1);
    @(negedge clk);
    chk("full_v0", {31'b0, bus.out0_valid}, 32'd1);
    chk("full_v1", {31'b0, bus.out1_valid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    chk("mrst_v0", {31'b0, bus.out0_valid}, 32'd0);
    chk("mrst_v1", {31'b0, bus.out1_valid}, 32'd0);
    chk("mrst_cnt0", {16'b0, bus.cnt0}, 32'd0);
    chk("mrst_cnt1", {16'b0, bus.cnt1}, 32'd0);
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    idle(4);
    chk("mrst_no_delivery_cnt0", {16'b0, bus.cnt0}, 32'd0);
    chk("mrst_no_delivery_cnt1", {16'b0, bus.cnt1}, 32'd0);

    // 5: 17 words to channel 1 of the 4-bit-counter instance
    w_acc = 0;
    wbus.in_valid = 1'b1; wbus.S = 1'b1;
    for (int n = 0; n < 60 && w_acc < 17; n++) begin
      wbus.I = w_acc;
      @(negedge clk);
      if (wbus.in_ready) w_acc++;
      @(posedge clk); #1;
    end
    wbus.in_valid = 1'b0;
    chk("wrap_accepts", w_acc, 32'd17);
    repeat (3) begin @(posedge clk); #1; end
    chk("wrap_cnt1", {28'b0, wbus.cnt1}, 32'd1);
    chk("wrap_cnt0", {28'b0, wbus.cnt0}, 32'd0);
    chk("wrap_y1_last", wbus.Y1, 32'd16);

    chk("sb_q0_empty", q0.size(), 32'd0);
    chk("sb_q1_empty", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
